fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline.
- Owns the program counter and drives the byte address to the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register, together with its PC and PC+4.
- Handles hazard-unit stalls, branch/jump redirects (with bubble insertion) and misaligned-PC faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.
- CNT_WIDTH, 32, width of the fetch counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall_f  input  1  hazard unit: hold PC and IF/ID
- redirect_valid  input  1  branch/jump taken; load redirect_pc
- redirect_pc  input  32  redirect target byte address
- imem_addr  output  32  byte address to instruction memory; equals PC register
- imem_rdata  input  32  instruction word; combinational, valid in the same cycle
- id_instr  output  32  IF/ID instruction
- id_pc  output  32  IF/ID PC of id_instr
- id_pc_plus4  output  32  IF/ID id_pc+4
- id_valid  output  1  IF/ID holds a real fetch packet
- id_misaligned  output  1  IF/ID packet is an instruction-address-misaligned fault
- fetch_count  output  CNT_WIDTH  number of valid packets delivered to ID

Behaviour:
- One clock, synchronous active-high reset. All state updates on the rising clk edge.
- imem_addr = pc_q (combinational). The instruction fetched at PC p appears on id_* one cycle later.
- Reset values:
  - pc_q = RESET_PC, state = FETCH
  - id_instr = NOP_INSTR, id_pc = 0, id_pc_plus4 = 0
  - id_valid = 0, id_misaligned = 0, fetch_count = 0
- Reset overrides every other input. Reset mid-stall or mid-fault returns cleanly to FETCH at RESET_PC.
- Per-cycle priority: rst > redirect_valid > stall_f > normal advance.
- States:
  - FETCH: normal operation.
  - FAULT: PC held after delivering one misaligned packet.
- Redirect (any state, even with stall_f = 1):
  - pc_q <= redirect_pc, state <= FETCH.
  - IF/ID <= bubble (id_valid 0, id_instr NOP_INSTR, id_misaligned 0; id_pc/id_pc_plus4 hold).
  - fetch_count unchanged.
  - A misaligned redirect_pc is accepted; the fault is raised on the following advance.
- Stall (no redirect): pc_q, state, all id_* outputs and fetch_count hold.
- Advance in FETCH with pc_q[1:0] == 0:
  - id_instr <= imem_rdata, id_pc <= pc_q, id_pc_plus4 <= pc_q+4.
  - id_valid <= 1, id_misaligned <= 0.
  - pc_q <= pc_q+4, fetch_count += 1.
- Advance in FETCH with pc_q[1:0] != 0:
  - id_instr <= NOP_INSTR, id_pc <= pc_q, id_pc_plus4 <= pc_q+4.
  - id_valid <= 1, id_misaligned <= 1.
  - pc_q holds, state <= FAULT, fetch_count += 1.
- Advance in FAULT: IF/ID <= bubble, pc_q holds. Only a redirect or reset leaves FAULT.
- Arithmetic:
  - PC+4 is modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
  - fetch_count wraps to 0 on overflow.
- Redirect to the current pc_q is legal: that address is refetched after a one-cycle bubble.
- imem_rdata is ignored on stall, redirect and FAULT cycles.

Test Plan:
- Reset then 4 free-running cycles, imem returns 32'h00A00093, ... → imem_addr sequence 0,4,8,C; id_pc 0,4,8 with id_valid=1 from the 2nd edge; fetch_count=3 after 4 edges.
- Assert stall_f for 3 cycles at pc_q=8 → imem_addr stays 8; id_pc=4, id_instr and fetch_count frozen; advance resumes at 8 after release.
- redirect_valid with redirect_pc=32'h40 while stall_f=1 → next cycle imem_addr=0x40, id_valid=0, id_instr=32'h13; following cycle id_pc=0x40, id_valid=1.
- Redirect to 32'h42 → bubble, then one packet with id_pc=0x42, id_misaligned=1, id_instr=32'h13; then id_valid=0 with imem_addr held at 0x42 until redirect to 0x100 restores fetching.
- Redirect to 32'hFFFF_FFFC, advance twice → id_pc=FFFF_FFFC with id_pc_plus4=0, then imem_addr=0 and id_pc=0.
- Assert rst while in FAULT with stall_f=1 → next cycle pc_q=RESET_PC, all outputs at reset values, state FETCH.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the instruction memory address and fills
// the IF/ID register, handling stalls, redirects and misaligned-PC faults.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_f,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          id_instr,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_pc_plus4,
  output logic                 id_valid,
  output logic                 id_misaligned,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [0:0] {StFetch, StFault} state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          id_instr_q, id_instr_d;
  logic [31:0]          id_pc_q, id_pc_d;
  logic [31:0]          id_pc_plus4_q, id_pc_plus4_d;
  logic                 id_valid_q, id_valid_d;
  logic                 id_misaligned_q, id_misaligned_d;
  logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        pc_misaligned;

  // PC+4 wraps modulo 2^32 by construction.
  assign pc_plus4      = pc_q + 32'd4;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    id_instr_d      = id_instr_q;
    id_pc_d         = id_pc_q;
    id_pc_plus4_d   = id_pc_plus4_q;
    id_valid_d      = id_valid_q;
    id_misaligned_d = id_misaligned_q;
    fetch_count_d   = fetch_count_q;

    if (redirect_valid) begin
      // Redirect wins over stall; IF/ID becomes a bubble, id_pc/id_pc_plus4 keep old values.
      pc_d            = redirect_pc;
      state_d         = StFetch;
      id_instr_d      = NOP_INSTR;
      id_valid_d      = 1'b0;
      id_misaligned_d = 1'b0;
    end else if (!stall_f) begin
      unique case (state_q)
        StFetch: begin
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 1'b1;
          if (pc_misaligned) begin
            // Deliver exactly one fault packet, then park until redirected.
            id_instr_d      = NOP_INSTR;
            id_misaligned_d = 1'b1;
            state_d         = StFault;
          end else begin
            id_instr_d      = imem_rdata;
            id_misaligned_d = 1'b0;
            pc_d            = pc_plus4;
          end
        end
        StFault: begin
          id_instr_d      = NOP_INSTR;
          id_valid_d      = 1'b0;
          id_misaligned_d = 1'b0;
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StFetch;
      pc_q            <= RESET_PC;
      id_instr_q      <= NOP_INSTR;
      id_pc_q         <= 32'd0;
      id_pc_plus4_q   <= 32'd0;
      id_valid_q      <= 1'b0;
      id_misaligned_q <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      id_instr_q      <= id_instr_d;
      id_pc_q         <= id_pc_d;
      id_pc_plus4_q   <= id_pc_plus4_d;
      id_valid_q      <= id_valid_d;
      id_misaligned_q <= id_misaligned_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign id_pc_plus4   = id_pc_plus4_q;
  assign id_valid      = id_valid_q;
  assign id_misaligned = id_misaligned_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push expected outputs, a monitor
// pops and compares them on the falling edge after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        id_misaligned;
  logic [31:0] fetch_count;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory model: distinct word per address, combinational.
  assign imem_rdata = 32'h00A0_0093 ^ {imem_addr[15:0], 16'h0000};

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013),
    .CNT_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_f       (stall_f),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid),
    .id_misaligned (id_misaligned),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected snapshot per rising edge, compared on the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("id_instr", id_instr, e.instr);
        chk("id_pc", id_pc, e.pc);
        chk("id_pc_plus4", id_pc_plus4, e.pc4);
        chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
        chk("id_misaligned", {31'd0, id_misaligned}, {31'd0, e.mis});
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] pc4,
                      input logic v, input logic m, input logic [31:0] cnt);
    exp_t e;
    rst            = r;
    stall_f        = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    e = '{addr: addr, instr: instr, pc: pc, pc4: pc4, valid: v, mis: m, cnt: cnt};
    exp_q.push_back(e);
    #2;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    //   rst st rv rpc            addr           instr          pc             pc4          v m cnt
    step(1, 0, 0, 32'h0,        32'h0,         NOP,           32'h0,         32'h0,        0,0, 0);
    // Free-running fetch.
    step(0, 0, 0, 32'h0,        32'h4,         32'h00A00093,  32'h0,         32'h4,        1,0, 1);
    step(0, 0, 0, 32'h0,        32'h8,         32'h00A40093,  32'h4,         32'h8,        1,0, 2);
    // Stall at pc 8 for three cycles.
    step(0, 1, 0, 32'h0,        32'h8,         32'h00A40093,  32'h4,         32'h8,        1,0, 2);
    step(0, 1, 0, 32'h0,        32'h8,         32'h00A40093,  32'h4,         32'h8,        1,0, 2);
    step(0, 1, 0, 32'h0,        32'h8,         32'h00A40093,  32'h4,         32'h8,        1,0, 2);
    step(0, 0, 0, 32'h0,        32'hC,         32'h00A80093,  32'h8,         32'hC,        1,0, 3);
    // Redirect wins over stall.
    step(0, 1, 1, 32'h40,       32'h40,        NOP,           32'h8,         32'hC,        0,0, 3);
    step(0, 0, 0, 32'h0,        32'h44,        32'h00E00093,  32'h40,        32'h44,       1,0, 4);
    // Misaligned redirect: bubble, fault packet, then parked.
    step(0, 0, 1, 32'h42,       32'h42,        NOP,           32'h40,        32'h44,       0,0, 4);
    step(0, 0, 0, 32'h0,        32'h42,        NOP,           32'h42,        32'h46,       1,1, 5);
    step(0, 0, 0, 32'h0,        32'h42,        NOP,           32'h42,        32'h46,       0,0, 5);
    step(0, 1, 0, 32'h0,        32'h42,        NOP,           32'h42,        32'h46,       0,0, 5);
    step(0, 0, 0, 32'h0,        32'h42,        NOP,           32'h42,        32'h46,       0,0, 5);
    step(0, 0, 1, 32'h100,      32'h100,       NOP,           32'h42,        32'h46,       0,0, 5);
    step(0, 0, 0, 32'h0,        32'h104,       32'h01A00093,  32'h100,       32'h104,      1,0, 6);
    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC,  NOP,           32'h100,       32'h104,      0,0, 6);
    step(0, 0, 0, 32'h0,        32'h0,         32'hFF5C0093,  32'hFFFFFFFC,  32'h0,        1,0, 7);
    step(0, 0, 0, 32'h0,        32'h4,         32'h00A00093,  32'h0,         32'h4,        1,0, 8);
    // Redirect to the current PC refetches it after one bubble.
    step(0, 0, 1, 32'h4,        32'h4,         NOP,           32'h0,         32'h4,        0,0, 8);
    step(0, 0, 0, 32'h0,        32'h8,         32'h00A40093,  32'h4,         32'h8,        1,0, 9);
    // Enter FAULT, then reset while stalled and redirecting.
    step(0, 0, 1, 32'h42,       32'h42,        NOP,           32'h4,         32'h8,        0,0, 9);
    step(0, 0, 0, 32'h0,        32'h42,        NOP,           32'h42,        32'h46,       1,1, 10);
    step(1, 1, 1, 32'h200,      32'h0,         NOP,           32'h0,         32'h0,        0,0, 0);
    step(0, 0, 0, 32'h0,        32'h4,         32'h00A00093,  32'h0,         32'h4,        1,0, 1);
    stall_f = 1'b0; redirect_valid = 1'b0; rst = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
